// File: rtl/jtag_pkg.sv
// Shared JTAG encodings: scan sequencer states, TAP states, TMS walk levels.
// Build option JTAG_SEQ_RUNTEST_EN adds the RUNTEST dwell state.
package jtag_pkg;

  typedef enum logic [3:0] {
    S_RST_SEQ,
    S_IDLE,
    S_GO_SEL_DR,
    S_GO_SEL_IR,
    S_GO_CAPTURE,
    S_GO_SHIFT,
    S_SHIFT,
    S_GO_UPDATE,
    S_GO_IDLE
`ifdef JTAG_SEQ_RUNTEST_EN
    , S_RUNTEST
`endif
  } seq_state_e;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_e;

  localparam logic TMS_TLR = 1'b1;
  localparam logic TMS_RTI = 1'b0;

endpackage

// File: rtl/jtag_scan_shifter.sv
// Scan datapath: TDI shift register, TDO capture, bit counter, response hold.
// Build option JTAG_SEQ_RUNTEST_EN does not affect this block.
module jtag_scan_shifter #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] data_i,
  input  logic               shift_i,
  input  logic               done_i,
  input  logic               tdo_i,
  output logic               tdi_o,
  output logic               last_o,
  output logic [MAX_LEN-1:0] rsp_data_o
);

  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_eff;

  always_comb begin
    len_eff = len_i;
    if (len_i == '0) begin
      len_eff = LEN_W'(1);
    end else if (len_i > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cap_d = cap_q;
    rsp_d = rsp_q;
    len_d = len_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cap_d = '0;
      len_d = len_eff;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q >> 1;
      cap_d = cap_q | ({{(MAX_LEN-1){1'b0}}, tdo_i} << cnt_q);
      cnt_d = cnt_q + LEN_W'(1);
    end
    // response only moves on completion so it holds through the next scan
    if (done_i) begin
      rsp_d = cap_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cap_q <= '0;
      rsp_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cap_q <= cap_d;
      rsp_q <= rsp_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign tdi_o      = shift_i & sr_q[0];
  assign last_o     = (cnt_q == len_q - LEN_W'(1));
  assign rsp_data_o = rsp_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG master scan sequencer: one IR/DR request -> TMS/TDI stream, TDO capture.
// Build option JTAG_SEQ_RUNTEST_EN adds a Run-Test/Idle dwell after each scan.
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int LEN_W       = 6,
  parameter int RST_TMS_CYC = 5,
  parameter int RUNTEST_CYC = 4
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_ir,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_data,
  input  logic               TDO,
  output logic               TMS,
  output logic               TDI,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data
);

  localparam int CW = $clog2(RST_TMS_CYC + RUNTEST_CYC + 2);

  seq_state_e    state_q, state_d;
  logic          ir_q, ir_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          accept;
  logic          shift;
  logic          last;
  logic          done;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign shift     = (state_q == S_SHIFT);
  assign rsp_valid = vld_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cyc_d   = cyc_q;
    vld_d   = 1'b0;
    done    = 1'b0;
    TMS     = TMS_RTI;
    unique case (state_q)
      S_RST_SEQ: begin
        TMS   = (cyc_q < CW'(RST_TMS_CYC)) ? TMS_TLR : TMS_RTI;
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(RST_TMS_CYC)) begin
          state_d = S_IDLE;
          cyc_d   = '0;
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_GO_SEL_DR;
          ir_d    = req_ir;
        end
      end
      S_GO_SEL_DR: begin
        TMS     = 1'b1;
        state_d = ir_q ? S_GO_SEL_IR : S_GO_CAPTURE;
      end
      S_GO_SEL_IR: begin
        TMS     = 1'b1;
        state_d = S_GO_CAPTURE;
      end
      S_GO_CAPTURE: state_d = S_GO_SHIFT;
      S_GO_SHIFT:   state_d = S_SHIFT;
      S_SHIFT: begin
        TMS = last;
        if (last) begin
          state_d = S_GO_UPDATE;
        end
      end
      S_GO_UPDATE: begin
        TMS     = 1'b1;
        state_d = S_GO_IDLE;
      end
`ifdef JTAG_SEQ_RUNTEST_EN
      S_GO_IDLE: begin
        state_d = S_RUNTEST;
        cyc_d   = '0;
      end
      S_RUNTEST: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(RUNTEST_CYC - 1)) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          vld_d   = 1'b1;
          done    = 1'b1;
        end
      end
`else
      S_GO_IDLE: begin
        state_d = S_IDLE;
        vld_d   = 1'b1;
        done    = 1'b1;
      end
`endif
      default: begin
        state_d = S_RST_SEQ;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= S_RST_SEQ;
      ir_q    <= 1'b0;
      vld_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      cyc_q   <= cyc_d;
    end
  end

  jtag_scan_shifter #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shifter (
    .clk_i      (TCK),
    .rst_i      (TRST),
    .load_i     (accept),
    .len_i      (req_len),
    .data_i     (req_data),
    .shift_i    (shift),
    .done_i     (done),
    .tdo_i      (TDO),
    .tdi_o      (TDI),
    .last_o     (last),
    .rsp_data_o (rsp_data)
  );

endmodule
